// File: rtl/col2im_pkg.sv
// col2im_pkg: definitions shared by col2im and its neighbours on the layer pipeline.
//   data_len   - word width of the signed Q8.10 fixed-point datapath
//   ADDR_W     - width of the shared patch-RAM address bus
//   ZERO/ONE   - Q8.10 constants
//   layer_e    - layer sequencing codes used by a top-level controller to drive load
//   map_index  - flat channel-major index of (channel, pixel) in an assembled map
package col2im_pkg;

    localparam int unsigned data_len = 18;
    localparam int unsigned ADDR_W   = 9;

    localparam logic [data_len-1:0] ZERO = '0;
    localparam logic [data_len-1:0] ONE  = 18'h00400;

    typedef enum logic [2:0] {
        LIDLE,
        LAYER1,
        LAYER2,
        LAYER3,
        LAYER4
    } layer_e;

    function automatic int unsigned map_index(input int unsigned c, input int unsigned pix,
                                              input int unsigned npix);
        return c * npix + pix;
    endfunction

endpackage

// File: rtl/col2im_if.sv
// col2im_if: request/RAM/result signals between col2im and its controller.
//   load  - level request: start and hold an assembly
//   relu  - clamp negatives to zero for the run started by load
//   din   - RAM read data, channel c at [c*DW +: DW]
//   valid - assembled map complete and stable on q
//   addr  - RAM read address
//   q     - feature map, word c*H*W + r*W + col at [idx*DW +: DW]
// master: controller side; slave: col2im.
interface col2im_if #(
    parameter int unsigned DW = col2im_pkg::data_len,
    parameter int unsigned CH = 32,
    parameter int unsigned H  = 5,
    parameter int unsigned W  = 6
) ();
    import col2im_pkg::*;

    logic                     load;
    logic                     relu;
    logic [CH*DW-1:0]         din;
    logic                     valid;
    logic [ADDR_W-1:0]        addr;
    logic [CH*H*W*DW-1:0]     q;

    modport master (output load, relu, din, input valid, addr, q);
    modport slave  (input load, relu, din, output valid, addr, q);

endinterface

// File: rtl/col2im_relu_word.sv
// col2im_relu_word: one-word combinational ReLU clamp.
//   en   - clamp enable
//   din  - signed word in
//   dout - din, or zero when en is set and din is negative
module col2im_relu_word
    import col2im_pkg::*;
#(
    parameter int unsigned DW = data_len
) (
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    always_comb begin
        dout = din;
        if (en && din[DW-1]) begin
            dout = '0;
        end
    end

endmodule

// File: rtl/col2im.sv
// col2im: walks H*W patch-RAM addresses, captures one CH-word vector per pixel (optionally
// ReLU-clamped) and presents the assembled channel-major feature map on q with valid.
//   clk, rst - clock and synchronous active-high reset
//   bus      - col2im_if slave: load/relu/din in, valid/addr/q out
module col2im
    import col2im_pkg::*;
#(
    parameter int unsigned DW   = data_len,
    parameter int unsigned CH   = 32,
    parameter int unsigned H    = 5,
    parameter int unsigned W    = 6,
    parameter int unsigned BASE = 0
) (
    input  logic     clk,
    input  logic     rst,
    col2im_if.slave  bus
);

    localparam int unsigned NPIX  = H * W;
    localparam int unsigned NWORD = CH * NPIX;
    localparam int unsigned PW    = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int unsigned IW    = (NWORD > 1) ? $clog2(NWORD) : 1;
    localparam logic [PW-1:0]     LAST   = PW'(NPIX - 1);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       p_q, p_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                valid_q, valid_d;
    logic                relu_q, relu_d;
    logic                cap_en_q, cap_en_d;
    logic [PW-1:0]       cap_idx_q, cap_idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            p_q       <= '0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            relu_q    <= 1'b0;
            cap_en_q  <= 1'b0;
            cap_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            relu_q    <= relu_d;
            cap_en_q  <= cap_en_d;
            cap_idx_q <= cap_idx_d;
        end
    end

    // cap_en/cap_idx trail the issued address by one cycle to match the RAM read latency.
    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        relu_d    = relu_q;
        cap_en_d  = 1'b0;
        cap_idx_d = cap_idx_q;
        unique case (state_q)
            StIdle: begin
                if (bus.load) begin
                    state_d = StRead;
                    relu_d  = bus.relu;
                    addr_d  = BASE_A;
                    p_d     = '0;
                end
            end
            StRead: begin
                if (!bus.load) begin
                    state_d = StIdle;
                end else begin
                    cap_en_d  = 1'b1;
                    cap_idx_d = p_q;
                    if (p_q == LAST) begin
                        state_d = StDrain;
                    end else begin
                        addr_d = BASE_A + ADDR_W'(p_q) + ADDR_W'(1);
                        p_d    = p_q + PW'(1);
                    end
                end
            end
            StDrain: begin
                state_d = bus.load ? StDone : StIdle;
            end
            StDone: begin
                if (bus.load) begin
                    valid_d = 1'b1;
                end else begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    logic [DW-1:0] cap_word [CH];

    for (genvar c = 0; c < CH; c++) begin : g_relu
        col2im_relu_word #(
            .DW (DW)
        ) u_relu (
            .en   (relu_q),
            .din  (bus.din[c*DW +: DW]),
            .dout (cap_word[c])
        );
    end

    // Gating with load drops the pending capture on the abort edge.
    logic cap_fire;
    assign cap_fire = cap_en_q && bus.load;

    logic [DW-1:0] mem_q [NWORD];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NWORD; i++) begin
                mem_q[i] <= '0;
            end
        end else if (cap_fire) begin
            for (int unsigned c = 0; c < CH; c++) begin
                mem_q[IW'(map_index(c, 32'(cap_idx_q), NPIX))] <= cap_word[c];
            end
        end
    end

    for (genvar i = 0; i < NWORD; i++) begin : g_q
        assign bus.q[i*DW +: DW] = mem_q[i];
    end

    assign bus.valid = valid_q;
    assign bus.addr  = addr_q;

endmodule

// File: doc/col2im.md
# col2im

Reassembles per-pixel channel vectors read back from the patch RAM into a full channel-major feature map for the next CNN layer. It is the read-side counterpart of `im2col`. `im2col` flattens a feature map into addressed RAM words. `col2im` walks the RAM addresses, captures one channel vector per pixel, optionally applies ReLU, and presents the assembled map on a single wide bus with a `valid` flag. It shares the RAM address bus with `im2col` and `dot` through the same load-gated muxing.

## Interface
- `DW`, 18: word width, signed Q8.10 fixed point (`data_len`).
- `CH`, 32: channels per pixel (words per RAM entry).
- `H`, 5: feature map rows.
- `W`, 6: feature map columns.
- `BASE`, 0: first RAM address read.
- `clk` input 1: clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `load` input 1: level request; high starts and holds an assembly, low aborts or releases.
- `relu` input 1: sampled with `load` at start; 1 means clamp negative words to 0 on capture.
- `din` input CH*DW: RAM read data; channel c at bits [c*DW +: DW].
- `valid` output 1: assembled map complete and stable on `q`.
- `addr` output 9: RAM read address.
- `q` output CH*H*W*DW: feature map; word index c*H*W + r*W + col at bits [idx*DW +: DW].

## Operation
- States:
  - IDLE: waiting for `load`.
  - READ: issuing addresses.
  - DRAIN: capturing the last RAM word.
  - DONE: holding `valid`.
- IDLE -> READ when `load`=1. `relu` is latched at that edge, `addr`<=BASE, and the pixel counter p<=0.
- READ:
  - Each cycle, `addr`<=BASE+p+1 and p increments.
  - At p=H*W-1, go to DRAIN; `addr` holds the last value.
- Capture pipeline: the RAM has one cycle of read latency. `din` sampled in cycle n belongs to the address presented in cycle n-1. A delayed capture index and capture-enable register track this.
- Capture writes word c of `din` into `q` index c*H*W + p_captured for all c in parallel.
  - If the latched `relu`=1 and bit DW-1 of a word is 1, write 0 in its place.
  - No other arithmetic and no saturation; values pass bit-exact.
- DRAIN: captures pixel H*W-1, then goes to DONE.
- DONE: `valid`=1 while `load`=1. When `load`=0, go to IDLE and `valid`<=0.
- `load`=0 in READ or DRAIN aborts to IDLE on the next edge. No further captures occur, `valid` stays 0, and partially written `q` is retained.
- `q` is otherwise held; it is only overwritten by captures of a new run.
- `addr` holds its last value in IDLE and DONE. The owner of the RAM bus gates it using `load`.
- BASE+H*W-1 must be ≤ 511; the address does not wrap.

## Timing
- Reset values: `valid`=0, `addr`=0, `q`=0, state IDLE, latched relu=0.
- `rst` has priority over `load` in the same cycle. Reset mid-run returns all outputs to their reset values on the next edge.
- Let `load` first be sampled high at edge t:
  - `addr`=BASE+k is visible during cycle t+1+k, for k=0..H*W-1.
  - `din` for pixel k is captured at edge t+2+k.
  - `valid` rises at edge t+H*W+2. Default: 32 cycles.
- `valid` falls one edge after `load` is sampled low.
- Re-asserting `load` in IDLE starts a new run; there is no minimum gap beyond one IDLE cycle.
- `relu` changes after the start edge have no effect on the current run.

## Structure
- Shared package/include: `data_len`, and the Q-format constants ZERO and ONE (18'h00400).
- Shared package/include: the layer state codes (`LIDLE`, `LAYER1`, …), so that a top-level controller can drive `load` per layer.
- Local state encoding (IDLE/READ/DRAIN/DONE) stays private.
- Natural sub-module: `relu_word`, a one-word combinational clamp instantiated CH times.
- Also in the block: the counter/FSM and the capture register file.

## Test plan
- Identity:
  - Stimulus: RAM entry p filled with all channels = 18'h00400, `relu`=0, `load` held.
  - Response: `valid` rises exactly 32 cycles after `load` is first sampled, and every word of `q` = 18'h00400.
- Index mapping:
  - Stimulus: RAM entry p, channel c = c*64+p.
  - Response: `q` word c*30+p equals c*64+p for all 960 words, and `addr` sequence = 0..29.
- ReLU:
  - Stimulus: alternating entries of 18'h3FC00 (-1.0) and 18'h00800 (2.0), with `relu`=1.
  - Response: negative positions read 0 and positive positions read 18'h00800.
  - Repeat with `relu`=0: 18'h3FC00 is retained.
- Abort:
  - Stimulus: drop `load` after 10 addresses.
  - Response: `valid` never rises, state is IDLE, words for p≥11 are unchanged from their prior contents.
  - A following full run completes normally.
- Reset mid-run:
  - Stimulus: assert `rst` at cycle 15 of a run.
  - Response: next edge gives `valid`=0, `addr`=0, `q`=0. With `load` still high after `rst` is released, a full run restarts from address 0.
- Release/restart:
  - Stimulus: hold `load` 5 cycles past `valid`, drop it for 1 cycle, then reassert.
  - Response: `valid` falls one edge after the drop, and the second run gives `valid` 32 cycles later.
  - Repeat with BASE=100: `addr` = 100..129.
